// File: rtl/mnist_nn_fp16_q88_stream.sv
// FP16 sample stream to signed Q8.8 converter with round-half-away-from-zero and saturation,
// feeding a show-ahead FIFO toward the MAC datapath; sticky overflow/saturation flags for CPU polling.
module mnist_nn_fp16_q88_stream #(
  parameter int DEPTH   = 8,
  parameter int LEVEL_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [15:0]        fp16_in,
  input  logic               fp16_valid,
  input  logic               flush,
  input  logic               clr_flags,
  output logic [15:0]        out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LEVEL_W-1:0] fifo_level,
  output logic               overflow,
  output logic               saturated
);
  localparam int AW = $clog2(DEPTH);

  logic              s1Valid_q, s1Sign_q, s1Nan_q, s1Inf_q, s1Zero_q;
  logic [4:0]        s1Exp_q;
  logic [10:0]       s1Mant_q;
  logic              s2Valid_q, s2Sat_q;
  logic [15:0]       s2Data_q;
  logic [LEVEL_W-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d, level_q, level_d;
  logic              outValid_q, outValid_d, overflow_q, overflow_d, saturated_q, saturated_d;
  logic [15:0]       mem [DEPTH];
  logic [31:0]       mag;
  logic [4:0]        sh;
  logic [15:0]       convRes;
  logic              convSat;
  logic              pop, full, push, drop;

  // Stage 1: split the FP16 word into fields and classify it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1Valid_q <= 1'b0;
      s1Sign_q  <= 1'b0;
      s1Exp_q   <= '0;
      s1Mant_q  <= '0;
      s1Nan_q   <= 1'b0;
      s1Inf_q   <= 1'b0;
      s1Zero_q  <= 1'b0;
    end else begin
      s1Valid_q <= fp16_valid && !flush;
      if (fp16_valid) begin
        s1Sign_q <= fp16_in[15];
        s1Exp_q  <= fp16_in[14:10];
        s1Mant_q <= {1'b1, fp16_in[9:0]};
        s1Nan_q  <= (fp16_in[14:10] == 5'd31) && (fp16_in[9:0] != 10'd0);
        s1Inf_q  <= (fp16_in[14:10] == 5'd31) && (fp16_in[9:0] == 10'd0);
        s1Zero_q <= (fp16_in[14:10] == 5'd0);
      end
    end
  end

  // Magnitude is m*2^(e-17); right shifts add half an output LSB first so ties round away from zero
  always_comb begin
    mag     = '0;
    sh      = '0;
    convRes = '0;
    convSat = 1'b0;
    if (s1Inf_q) begin
      convRes = s1Sign_q ? 16'h8000 : 16'h7FFF;
      convSat = 1'b1;
    end else if (!s1Nan_q && !s1Zero_q) begin
      if (s1Exp_q >= 5'd17) begin
        mag = {21'd0, s1Mant_q} << (s1Exp_q - 5'd17);
      end else begin
        sh = 5'd17 - s1Exp_q;
        if (sh <= 5'd12) begin
          mag = ({21'd0, s1Mant_q} + (32'd1 << (sh - 5'd1))) >> sh;
        end
      end
      if (!s1Sign_q && mag > 32'd32767) begin
        convRes = 16'h7FFF;
        convSat = 1'b1;
      end else if (s1Sign_q && mag >= 32'd32768) begin
        convRes = 16'h8000;
        convSat = (mag != 32'd32768);
      end else begin
        convRes = s1Sign_q ? (16'd0 - mag[15:0]) : mag[15:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2Valid_q <= 1'b0;
      s2Data_q  <= '0;
      s2Sat_q   <= 1'b0;
    end else begin
      s2Valid_q <= s1Valid_q && !flush;
      if (s1Valid_q) begin
        s2Data_q <= convRes;
        s2Sat_q  <= convSat;
      end
    end
  end

  // A full FIFO still accepts a push when the head is popped on the same edge
  assign pop  = outValid_q && out_ready;
  assign full = (level_q == LEVEL_W'(DEPTH));
  assign push = s2Valid_q && (!full || pop) && !flush;
  assign drop = s2Valid_q && full && !pop && !flush;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
    end else begin
      if (push) wrPtr_d = wrPtr_q + LEVEL_W'(1);
      if (pop)  rdPtr_d = rdPtr_q + LEVEL_W'(1);
    end
    level_d     = wrPtr_d - rdPtr_d;
    outValid_d  = (level_d != '0);
    overflow_d  = (overflow_q && !clr_flags) || drop;
    saturated_d = (saturated_q && !clr_flags) || (s2Valid_q && s2Sat_q && !flush);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      level_q     <= '0;
      outValid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      saturated_q <= 1'b0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      level_q     <= level_d;
      outValid_q  <= outValid_d;
      overflow_q  <= overflow_d;
      saturated_q <= saturated_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr_q[AW-1:0]] <= s2Data_q;
  end

  assign out_data   = outValid_q ? mem[rdPtr_q[AW-1:0]] : 16'h0000;
  assign out_valid  = outValid_q;
  assign fifo_level = level_q;
  assign overflow   = overflow_q;
  assign saturated  = saturated_q;

endmodule
